mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative signed multiply/divide unit producing the HI/LO pair for MULT and DIV.
//  Successor to the fixed 32-bit mult/div blocks in the multicycle MIPS datapath.
//  Driven by the control FSM through start pulses; it stalls the FSM via busy and signals completion with done.
//  Adds the following over the fixed blocks: generic width, a start/busy/done handshake,
//  a defined MIN/-1 result, and optional divide-by-zero exception reporting.
// PARAMETERS
//  WIDTH  32  operand width and HI/LO width; legal range 4..64.
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  mult_start in   1      request signed multiply; single-cycle pulse
//  div_start  in   1      request signed divide; single-cycle pulse
//  op_a       in   WIDTH  multiplicand / dividend (register A)
//  op_b       in   WIDTH  multiplier / divisor (register B)
//  hi         out  WIDTH  multiply: upper product half; divide: remainder
//  lo         out  WIDTH  multiply: lower product half; divide: quotient
//  busy       out  1      operation in progress; starts are ignored while high
//  done       out  1      one-cycle pulse; hi/lo hold the new result
//  div_zero   out  1      one-cycle pulse when a divide by zero is detected (DIVZERO_EXCP_EN only)
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; hi, lo, busy, done, div_zero=0. An in-flight operation is aborted.
//  States and transitions:
//   - IDLE: on start -> MULT or DIV.
//   - MULT / DIV: count WIDTH cycles, then -> FIX.
//   - FIX -> DONE.
//   - DONE -> IDLE.
//  Start capture:
//   - A start is sampled only in IDLE. op_a and op_b are latched on that same edge (edge E0).
//   - mult_start and div_start together: multiply wins; the divide is dropped.
//   - A start while busy=1 is ignored, with no queuing.
//  busy: 1 from after E0 until the edge that enters DONE. It is 0 in DONE and IDLE.
//  Iteration: one step per edge, E1..E_WIDTH. An internal WIDTH-bit counter counts 0..WIDTH-1.
//  MULT: magnitude shift-add on |a| and |b|. The 2*WIDTH-bit product is negated in FIX when sign(a)^sign(b).
//  DIV: restoring division on |a| and |b|. In FIX:
//   - Quotient is negated if sign(a)^sign(b), giving truncation toward zero.
//   - Remainder is negated if sign(a), so the remainder takes the dividend's sign.
//  Overflow case: dividend = MIN (1 followed by zeros) and divisor = -1 gives lo=MIN, hi=0, with no flag.
//  Result write: hi/lo are written at E_{WIDTH+1} (FIX->DONE).
//   - done=1 for exactly the cycle after E_{WIDTH+1}.
//   - Latency from the start edge to done high is WIDTH+2 cycles (34 for WIDTH=32).
//  hi/lo hold their value between operations. They are never partially updated during iteration.
//  A new start is accepted in the cycle after done, i.e. in IDLE.
// CONFIGURATION
//  Macro DIVZERO_EXCP_EN.
//  Defined:
//   - A divide with op_b=0 goes IDLE->DONE directly.
//   - done=1 and div_zero=1 for one cycle, 1 cycle after E0.
//   - hi/lo are unchanged.
//  Undefined:
//   - div_zero is tied 0.
//   - A divide by zero runs the full latency.
//   - Result: lo = all ones (quotient), hi = op_a (remainder).
// TESTING
//  1. mult op_a=7, op_b=-3 (WIDTH=32) -> done at +34 cycles; hi=FFFFFFFF, lo=FFFFFFEB.
//  2. div op_a=-7, op_b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; busy high for exactly 33 cycles.
//  3. div op_a=80000000, op_b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
//  4. div op_b=0, op_a=5: with the macro -> div_zero=done=1 at +1 cycle, hi/lo unchanged;
//     without it -> lo=FFFFFFFF, hi=00000005 at +34 cycles.
//  5. mult_start and div_start in the same cycle, then mult_start again at +5 -> one multiply only, a single done.
//  6. reset low at +10 of a multiply -> busy=0 and hi=lo=0 immediately;
//     a new div after release completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit (shift-add MULT, restoring DIV) producing HI/LO.
// Optional macro DIVZERO_EXCP_EN: divide by zero skips iteration and pulses div_zero with done.

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_signA;
  logic               r_signB;
  logic               r_bZero;

  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_opBZero;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prodRes;
  logic [WIDTH-1:0]   w_quoRes;
  logic [WIDTH-1:0]   w_remRes;

  assign w_absA    = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_absB    = op_b[WIDTH-1] ? -op_b : op_b;
  assign w_opBZero = (op_b == '0);

  // r_acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mag};

  // A zero divisor forces an all-ones quotient; the remainder naturally equals op_a
  assign w_prodRes = (r_signA ^ r_signB) ? -r_acc : r_acc;
  assign w_quoRes  = r_bZero ? '1 :
                     ((r_signA ^ r_signB) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_remRes  = r_signA ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mult_start) begin
          w_next = MULT;
        end else if (div_start) begin
`ifdef DIVZERO_EXCP_EN
          if (w_opBZero) w_next = DONE;
          else           w_next = DIV;
`else
          w_next = DIV;
`endif
        end
      end
      MULT: begin
        busy = 1'b1;
        if (r_count == LAST) w_next = FIX;
      end
      DIV: begin
        busy = 1'b1;
        if (r_count == LAST) w_next = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_mag   <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_isDiv <= 1'b0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_bZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mult_start || div_start) begin
            r_isDiv <= ~mult_start;
            r_signA <= op_a[WIDTH-1];
            r_signB <= op_b[WIDTH-1];
            r_bZero <= w_opBZero;
            r_count <= '0;
            if (mult_start) begin
              r_acc <= {{WIDTH{1'b0}}, w_absB};
              r_mag <= w_absA;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_absA};
              r_mag <= w_absB;
            end
          end
        end
        MULT: begin
          r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
          r_count <= r_count + ONE;
        end
        DIV: begin
          // No borrow out of the trial subtraction means the divisor fits
          if (!w_diff[WIDTH]) r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          else                r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          r_count <= r_count + ONE;
        end
        FIX: begin
          if (r_isDiv) begin
            r_hi <= w_remRes;
            r_lo <= w_quoRes;
          end else begin
            r_hi <= w_prodRes[2*WIDTH-1:WIDTH];
            r_lo <= w_prodRes[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVZERO_EXCP_EN
  logic r_dz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_dz <= 1'b0;
    else if (r_state == IDLE)  r_dz <= ~mult_start & div_start & w_opBZero;
  end

  assign div_zero = r_dz & (r_state == DONE);
`else
  assign div_zero = 1'b0;
`endif

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit (WIDTH=32) against a signed-arithmetic model.
// Expectations follow DIVZERO_EXCP_EN when it is defined for the build.

module tb_mult_div_unit;

  localparam int          W   = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        multStart = 1'b0;
  logic        divStart = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divZero;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(resetN), .mult_start(multStart), .div_start(divStart),
    .op_a(opA), .op_b(opB), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(divZero)
  );

  // Signed reference: returns {hi, lo}
  function automatic logic [63:0] refModel(input bit isMult, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int     sa, sb, q, r;
    if (isMult) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (a == MIN && b == 32'hFFFF_FFFF) return {32'h0, MIN};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  function automatic bit excpCase(input bit isMult, input logic [31:0] b);
`ifdef DIVZERO_EXCP_EN
    return !isMult && (b == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return MIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Pulses a start, then follows the operation until done (bounded) and steps into IDLE
  task automatic doOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                      output int cycles, output int busyCnt, output bit dzAtDone, output bit hiloMoved);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    cycles = -1; busyCnt = 0; dzAtDone = 1'b0; hiloMoved = 1'b0;
    @(negedge clk);
    multStart = m; divStart = d; opA = a; opB = b;
    @(posedge clk); #1;
    multStart = 1'b0; divStart = 1'b0; opA = $urandom; opB = $urandom;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        cycles = k;
        dzAtDone = divZero;
        break;
      end
      if (busy) busyCnt++;
      if (divZero) dzAtDone = 1'b1;
      if (hi !== hi0 || lo !== lo0) hiloMoved = 1'b1;
      @(posedge clk); #1;
    end
    if (cycles > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (hi !== 32'h0)   begin failures++; $display("[TB] FAIL reset hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)   begin failures++; $display("[TB] FAIL reset lo: got %h expected %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    checks++; if (divZero !== 1'b0) begin failures++; $display("[TB] FAIL reset div_zero: got %b expected 0", divZero); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    int cyc, bc; bit dz, mv;
    doOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, cyc, bc, dz, mv);
    checks++; if (cyc != W + 2)          begin failures++; $display("[TB] FAIL mult7 latency: got %0d expected %0d", cyc, W + 2); end
    checks++; if (hi !== 32'hFFFF_FFFF)  begin failures++; $display("[TB] FAIL mult7 hi: got %h expected FFFFFFFF", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB)  begin failures++; $display("[TB] FAIL mult7 lo: got %h expected FFFFFFEB", lo); end
    doOp(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, cyc, bc, dz, mv);
    checks++; if (bc != W + 1)           begin failures++; $display("[TB] FAIL div-7 busy cycles: got %0d expected %0d", bc, W + 1); end
    checks++; if (lo !== 32'hFFFF_FFFD)  begin failures++; $display("[TB] FAIL div-7 lo: got %h expected FFFFFFFD", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF)  begin failures++; $display("[TB] FAIL div-7 hi: got %h expected FFFFFFFF", hi); end
    doOp(1'b0, 1'b1, MIN, 32'hFFFF_FFFF, cyc, bc, dz, mv);
    checks++; if (lo !== MIN)            begin failures++; $display("[TB] FAIL minover lo: got %h expected %h", lo, MIN); end
    checks++; if (hi !== 32'h0)          begin failures++; $display("[TB] FAIL minover hi: got %h expected 0", hi); end
    checks++; if (dz !== 1'b0)           begin failures++; $display("[TB] FAIL minover div_zero: got %b expected 0", dz); end
    expHi = hi; expLo = lo;
  endtask

  task automatic test_divzero();
    int cyc, bc; bit dz, mv;
    logic [63:0] r;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'd5 : 32'hFFFF_FFF7;
      doOp(1'b0, 1'b1, a, 32'h0, cyc, bc, dz, mv);
`ifdef DIVZERO_EXCP_EN
      checks++; if (cyc != 1)      begin failures++; $display("[TB] FAIL divzero latency: got %0d expected 1", cyc); end
      checks++; if (dz !== 1'b1)   begin failures++; $display("[TB] FAIL divzero flag: got %b expected 1", dz); end
      checks++; if (bc != 0)       begin failures++; $display("[TB] FAIL divzero busy: got %0d expected 0", bc); end
`else
      r = refModel(1'b0, a, 32'h0);
      expHi = r[63:32]; expLo = r[31:0];
      checks++; if (cyc != W + 2)  begin failures++; $display("[TB] FAIL divzero latency: got %0d expected %0d", cyc, W + 2); end
      checks++; if (dz !== 1'b0)   begin failures++; $display("[TB] FAIL divzero flag: got %b expected 0", dz); end
`endif
      checks++; if (hi !== expHi)  begin failures++; $display("[TB] FAIL divzero hi: got %h expected %h", hi, expHi); end
      checks++; if (lo !== expLo)  begin failures++; $display("[TB] FAIL divzero lo: got %h expected %h", lo, expLo); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] a, b, gotHi, gotLo;
    logic [63:0] r;
    int doneCnt;
    a = $urandom; b = $urandom;
    r = refModel(1'b1, a, b);
    @(negedge clk);
    multStart = 1'b1; divStart = 1'b1; opA = a; opB = b;
    @(posedge clk); #1;
    multStart = 1'b0; divStart = 1'b0;
    doneCnt = 0; gotHi = hi; gotLo = lo;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      multStart = (k == 5);
      opA = $urandom; opB = $urandom;
      @(posedge clk); #1;
      multStart = 1'b0;
      if (done) begin
        doneCnt++;
        gotHi = hi; gotLo = lo;
      end
    end
    checks++; if (doneCnt != 1)     begin failures++; $display("[TB] FAIL collision done count: got %0d expected 1", doneCnt); end
    checks++; if (gotHi !== r[63:32]) begin failures++; $display("[TB] FAIL collision hi: got %h expected %h", gotHi, r[63:32]); end
    checks++; if (gotLo !== r[31:0])  begin failures++; $display("[TB] FAIL collision lo: got %h expected %h", gotLo, r[31:0]); end
    expHi = r[63:32]; expLo = r[31:0];
  endtask

  task automatic test_ignored_starts();
    logic [31:0] a, b;
    logic [63:0] r;
    bit seen;
    int extra;
    a = $urandom; b = $urandom;
    r = refModel(1'b1, a, b);
    @(negedge clk);
    multStart = 1'b1; opA = a; opB = b;
    @(posedge clk); #1;
    multStart = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      divStart = (k == 3); multStart = (k == 8);
      opA = $urandom; opB = $urandom | 32'h1;
      @(posedge clk); #1;
      divStart = 1'b0; multStart = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1)    begin failures++; $display("[TB] FAIL busy-start done seen: got %b expected 1", seen); end
    checks++; if (hi !== r[63:32])  begin failures++; $display("[TB] FAIL busy-start hi: got %h expected %h", hi, r[63:32]); end
    checks++; if (lo !== r[31:0])   begin failures++; $display("[TB] FAIL busy-start lo: got %h expected %h", lo, r[31:0]); end
    expHi = r[63:32]; expLo = r[31:0];
    // A start presented while still in the done cycle must be dropped
    @(negedge clk);
    multStart = 1'b1; opA = $urandom; opB = $urandom;
    @(posedge clk); #1;
    multStart = 1'b0;
    extra = 0;
    repeat (10) begin
      if (busy || done) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0)       begin failures++; $display("[TB] FAIL done-cycle start activity: got %0d expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; bit dz, mv;
    logic [31:0] a, b;
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom | 32'h1;
      r = refModel(i[0], a, b);
      doOp(i[0], !i[0], a, b, cyc, bc, dz, mv);
      checks++; if (cyc != W + 2)    begin failures++; $display("[TB] FAIL b2b[%0d] latency: got %0d expected %0d", i, cyc, W + 2); end
      checks++; if ({hi, lo} !== r)  begin failures++; $display("[TB] FAIL b2b[%0d] result: got %h expected %h", i, {hi, lo}, r); end
      expHi = r[63:32]; expLo = r[31:0];
    end
  endtask

  task automatic test_random();
    int cyc, bc, expCyc; bit dz, mv, m, ex;
    logic [31:0] a, b;
    logic [63:0] r;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = pickOperand(); b = pickOperand();
      ex = excpCase(m, b);
      if (!ex) begin
        r = refModel(m, a, b);
        expHi = r[63:32]; expLo = r[31:0];
      end
      expCyc = ex ? 1 : W + 2;
      doOp(m, !m, a, b, cyc, bc, dz, mv);
      checks++; if (cyc != expCyc)  begin failures++; $display("[TB] FAIL rand[%0d] latency m=%0d a=%h b=%h: got %0d expected %0d", i, m, a, b, cyc, expCyc); end
      checks++; if (hi !== expHi)   begin failures++; $display("[TB] FAIL rand[%0d] hi m=%0d a=%h b=%h: got %h expected %h", i, m, a, b, hi, expHi); end
      checks++; if (lo !== expLo)   begin failures++; $display("[TB] FAIL rand[%0d] lo m=%0d a=%h b=%h: got %h expected %h", i, m, a, b, lo, expLo); end
      checks++; if (dz !== ex)      begin failures++; $display("[TB] FAIL rand[%0d] div_zero: got %b expected %b", i, dz, ex); end
      checks++; if (mv !== 1'b0)    begin failures++; $display("[TB] FAIL rand[%0d] hi/lo changed before done: got %b expected 0", i, mv); end
    end
  endtask

  task automatic test_abort();
    int cyc, bc; bit dz, mv;
    logic [31:0] a, b;
    logic [63:0] r;
    doOp(1'b1, 1'b0, 32'd12345, 32'hFFFF_FD4A, cyc, bc, dz, mv);
    @(negedge clk);
    multStart = 1'b1; opA = $urandom; opB = $urandom;
    @(posedge clk); #1;
    multStart = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0)   begin failures++; $display("[TB] FAIL abort hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0)   begin failures++; $display("[TB] FAIL abort lo: got %h expected 0", lo); end
    @(negedge clk);
    resetN = 1'b1;
    a = $urandom; b = $urandom_range(1, 1000);
    r = refModel(1'b0, a, b);
    doOp(1'b0, 1'b1, a, b, cyc, bc, dz, mv);
    checks++; if (cyc != W + 2)   begin failures++; $display("[TB] FAIL post-abort latency: got %0d expected %0d", cyc, W + 2); end
    checks++; if ({hi, lo} !== r) begin failures++; $display("[TB] FAIL post-abort result: got %h expected %h", {hi, lo}, r); end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_divzero();
    test_collision();
    test_ignored_starts();
    test_back_to_back();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
